// File: rtl/seq_pattern_gen_if.sv
// Bundles the load/control inputs and serial outputs of seq_pattern_gen.
//   master: drives load, pat, len, mode, start, stop, en; observes q, frame, busy, done
//   slave : the pattern generator side
interface seq_pattern_gen_if #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) ();
  logic               load;
  logic [MAX_LEN-1:0] pat;
  logic [LW-1:0]      len;
  logic               mode;
  logic               start;
  logic               stop;
  logic               en;
  logic               q;
  logic               frame;
  logic               busy;
  logic               done;

  modport master (
    output load, pat, len, mode, start, stop, en,
    input  q, frame, busy, done
  );

  modport slave (
    input  load, pat, len, mode, start, stop, en,
    output q, frame, busy, done
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator. Shifts out pat_r[len_r-1:0] MSB-first, one bit per
// enabled cycle, in repeat or one-shot mode, with pause (en=0), abort (stop)
// and a single-slot pending reload applied at period boundaries.
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-high reset
//   bus        : seq_pattern_gen_if.slave (load/pat/len/mode/start/stop/en in,
//                q/frame/busy/done out)
//   period_cnt : completed-period counter, saturating; present only when the
//                macro SEQSIG_PERIOD_CNT_EN is defined
module seq_pattern_gen #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  seq_pattern_gen_if.slave   bus
`ifdef SEQSIG_PERIOD_CNT_EN
  ,
  output logic [15:0]        period_cnt
`endif
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StPause = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      idx_q, idx_d;
  logic               mode_q, mode_d;
  logic               q_q, q_d;
  logic               frame_q, frame_d;
  logic               done_q, done_d;
  logic               pend_vld_q, pend_vld_d;
  logic [MAX_LEN-1:0] pend_pat_q, pend_pat_d;
  logic [LW-1:0]      pend_len_q, pend_len_d;

  logic [LW-1:0]      in_len;
  logic [MAX_LEN-1:0] nxt_pat;
  logic [LW-1:0]      nxt_len;
  logic [LW-1:0]      idx_m1;
  logic [MAX_LEN-1:0] sh_adv;
  logic [MAX_LEN-1:0] sh_wrap;

`ifdef SEQSIG_PERIOD_CNT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    len_d      = len_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    q_d        = q_q;
    frame_d    = frame_q;
    done_d     = 1'b0;
    pend_vld_d = pend_vld_q;
    pend_pat_d = pend_pat_q;
    pend_len_d = pend_len_q;
`ifdef SEQSIG_PERIOD_CNT_EN
    cnt_d      = cnt_q;
`endif

    in_len = bus.len;
    if (bus.len == '0 || bus.len > LW'(MAX_LEN)) in_len = LW'(MAX_LEN);

    // Pattern for the next period: a load on this very edge wins over the
    // pending slot. The slot is always empty in IDLE, so this also serves start.
    nxt_pat = bus.load ? bus.pat : (pend_vld_q ? pend_pat_q : pat_q);
    nxt_len = bus.load ? in_len  : (pend_vld_q ? pend_len_q : len_q);

    idx_m1  = idx_q - LW'(1);
    sh_adv  = pat_q >> idx_m1;
    sh_wrap = nxt_pat >> (nxt_len - LW'(1));

    case (state_q)
      StRun, StPause: begin
        if (bus.stop) begin
          state_d    = StIdle;
          q_d        = 1'b0;
          frame_d    = 1'b0;
          idx_d      = '0;
          pend_vld_d = 1'b0;
        end else begin
          if (bus.load) begin
            pend_vld_d = 1'b1;
            pend_pat_d = bus.pat;
            pend_len_d = in_len;
          end
          if (!bus.en) begin
            state_d = StPause;
          end else begin
            state_d = StRun;
            if (idx_q == '0) begin
              // Period boundary: bit 0 has been shown.
              pat_d      = nxt_pat;
              len_d      = nxt_len;
              pend_vld_d = 1'b0;
`ifdef SEQSIG_PERIOD_CNT_EN
              if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`endif
              if (mode_q) begin
                state_d = StIdle;
                idx_d   = '0;
                q_d     = 1'b0;
                frame_d = 1'b0;
                done_d  = 1'b1;
              end else begin
                idx_d   = nxt_len - LW'(1);
                q_d     = sh_wrap[0];
                frame_d = 1'b1;
              end
            end else begin
              idx_d   = idx_m1;
              q_d     = sh_adv[0];
              frame_d = 1'b0;
            end
          end
        end
      end
      default: begin
        if (bus.load) begin
          pat_d = bus.pat;
          len_d = in_len;
        end
        if (bus.start && !bus.stop) begin
          state_d = StRun;
          mode_d  = bus.mode;
          idx_d   = nxt_len - LW'(1);
          q_d     = sh_wrap[0];
          frame_d = 1'b1;
`ifdef SEQSIG_PERIOD_CNT_EN
          cnt_d   = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pat_q      <= '0;
      len_q      <= LW'(MAX_LEN);
      idx_q      <= '0;
      mode_q     <= 1'b0;
      q_q        <= 1'b0;
      frame_q    <= 1'b0;
      done_q     <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_pat_q <= '0;
      pend_len_q <= LW'(MAX_LEN);
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      q_q        <= q_d;
      frame_q    <= frame_d;
      done_q     <= done_d;
      pend_vld_q <= pend_vld_d;
      pend_pat_q <= pend_pat_d;
      pend_len_q <= pend_len_d;
    end
  end

`ifdef SEQSIG_PERIOD_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign period_cnt = cnt_q;
`endif

  assign bus.q     = q_q;
  assign bus.frame = frame_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q != StIdle);

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen (MAX_LEN=16) with hand-computed outputs.
module tb_seq_pattern_gen;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  seq_pattern_gen_if #(.MAX_LEN(16)) bus ();

`ifdef SEQSIG_PERIOD_CNT_EN
  logic [15:0] period_cnt;
  seq_pattern_gen #(.MAX_LEN(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .period_cnt (period_cnt)
  );
`else
  seq_pattern_gen #(.MAX_LEN(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic eq, input logic ef, input logic eb,
                         input logic ed);
    chk({tag, ".q"},     32'(bus.q),     32'(eq));
    chk({tag, ".frame"}, 32'(bus.frame), 32'(ef));
    chk({tag, ".busy"},  32'(bus.busy),  32'(eb));
    chk({tag, ".done"},  32'(bus.done),  32'(ed));
  endtask

  initial begin
    logic [11:0] exp_q;
    logic [11:0] exp_f;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.load = 1'b0; bus.pat = '0; bus.len = '0; bus.mode = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.en = 1'b1;
    repeat (2) tick();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SEQSIG_PERIOD_CNT_EN
    chk("reset.cnt", 32'(period_cnt), 32'd0);
`endif
    rst = 1'b0;
    tick();
    chk_out("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Repeat mode, len 6: 1,1,0,1,0,0 with frame every 6 cycles
    bus.load = 1'b1; bus.pat = 16'b110100; bus.len = 5'd6;
    tick();
    bus.load = 1'b0;
    chk_out("s1.load", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    exp_q = 12'b110100_110100;
    exp_f = 12'b100000_100000;
    for (int i = 0; i < 12; i++) begin
      tick();
      bus.start = 1'b0;
      chk_out($sformatf("s1.b%0d", i), exp_q[11-i], exp_f[11-i], 1'b1, 1'b0);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_out("s1.stop", 1'b0, 1'b0, 1'b0, 1'b0);

    // One-shot len 3, loaded together with start
    bus.load = 1'b1; bus.pat = 16'b101; bus.len = 5'd3; bus.mode = 1'b1; bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0; bus.mode = 1'b0;
    chk_out("s2.b2", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("s2.b1", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("s2.b0", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("s2.done", 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef SEQSIG_PERIOD_CNT_EN
    chk("s2.cnt", 32'(period_cnt), 32'd1);
`endif
    tick();
    chk_out("s2.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Pause for 3 cycles on bit 2 of len 4 pattern 1100
    bus.load = 1'b1; bus.pat = 16'b1100; bus.len = 5'd4; bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    chk_out("s3.b3", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("s3.b2", 1'b1, 1'b0, 1'b1, 1'b0);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("s3.hold%0d", i), 1'b1, 1'b0, 1'b1, 1'b0);
    end
    bus.en = 1'b1;
    tick();
    chk_out("s3.b1", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("s3.b0", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("s3.wrap", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("s3.b2b", 1'b1, 1'b0, 1'b1, 1'b0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_out("s3.stop", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("s3.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Pending reload mid-period, start while busy ignored
    bus.load = 1'b1; bus.pat = 16'b1111; bus.len = 5'd4; bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    chk_out("s4.b3", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("s4.b2", 1'b1, 1'b0, 1'b1, 1'b0);
    bus.load = 1'b1; bus.pat = 16'b1000; bus.len = 5'd4;
    tick();
    bus.load = 1'b0;
    chk_out("s4.b1", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("s4.b0", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("s4.n3", 1'b1, 1'b1, 1'b1, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_out("s4.n2", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("s4.n1", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("s4.n0", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("s4.m3", 1'b1, 1'b1, 1'b1, 1'b0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_out("s4.stop", 1'b0, 1'b0, 1'b0, 1'b0);

    // start together with stop in IDLE stays idle
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk_out("s5.ss", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("s5.ss2", 1'b0, 1'b0, 1'b0, 1'b0);

    // len 0 clamps to 16: bit 15 then bit 14
    bus.load = 1'b1; bus.pat = 16'h8001; bus.len = 5'd0; bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    chk_out("s6.b15", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("s6.b14", 1'b0, 1'b0, 1'b1, 1'b0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

    // len 1 repeat: constant q with frame high
    bus.load = 1'b1; bus.pat = 16'h0001; bus.len = 5'd1; bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("s7.c%0d", i), 1'b1, 1'b1, 1'b1, 1'b0);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

    // Asynchronous reset mid-period
    bus.load = 1'b1; bus.pat = 16'b1111; bus.len = 5'd4; bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    tick();
    chk_out("s8.run", 1'b1, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_out("s8.rst", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SEQSIG_PERIOD_CNT_EN
    chk("s8.cnt", 32'(period_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_out("s8.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    // Reset pattern is all zeros with len 16
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_out("s8.start", 1'b0, 1'b1, 1'b1, 1'b0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_out("s8.stop", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum pattern length in bits (range 2..64).
REQ-002 SHALL have parameter LW, default $clog2(MAX_LEN+1), width of len port.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port load  input  1  sample pat/len into shadow registers.
REQ-006 SHALL have port pat  input  MAX_LEN  pattern bits.
REQ-007 SHALL have port len  input  LW  period length in bits.
REQ-008 SHALL have port mode  input  1  0 = repeat, 1 = one-shot; sampled on start.
REQ-009 SHALL have port start  input  1  begin sequence.
REQ-010 SHALL have port stop  input  1  abort sequence.
REQ-011 SHALL have port en  input  1  advance enable; low pauses output.
REQ-012 SHALL have port q  output  1  registered serial pattern bit.
REQ-013 SHALL have port frame  output  1  high while q carries bit len-1 (first bit of period).
REQ-014 SHALL have port busy  output  1  high in RUN or PAUSE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at one-shot completion.

Function
REQ-016 SHALL use states IDLE, RUN and PAUSE.
REQ-017 SHALL clamp len==0 or len>MAX_LEN to MAX_LEN when latched.
REQ-018 SHALL, in IDLE, latch pat/len on the load edge.
REQ-019 SHALL, while busy, hold load in a single pending slot (latest load wins) and apply it at the next period boundary, i.e. after bit 0 is shown.
REQ-020 SHALL emit bits MSB-first within the period: index len_r-1 down to 0.
REQ-021 SHALL, on a start edge in IDLE, enter RUN and drive q=pat_r[len_r-1] and frame=1 in the cycle after that edge (latency 1).
REQ-022 SHALL, on a load+start edge in IDLE, use the newly loaded pattern.
REQ-023 SHALL advance one bit per cycle while en=1 in RUN.
REQ-024 SHALL, when en=0, go RUN->PAUSE with q, frame and index held; en=1 returns PAUSE->RUN and resumes at the next index.
REQ-025 SHALL, in repeat mode, wrap index 0 -> len_r-1 with no gap cycle and reassert frame.
REQ-026 SHALL, in one-shot mode, after bit 0 go to IDLE and pulse done for one cycle, with q=0 and busy=0 in that cycle.
REQ-027 SHALL, on stop in RUN or PAUSE, go to IDLE next edge with q=0, no done pulse, and any pending load discarded.
REQ-028 SHALL give stop priority when start and stop are asserted together; start while busy SHALL be ignored.
REQ-029 SHALL ignore stop asserted in IDLE.
REQ-030 SHALL support len_r==1 as a constant q=pat_r[0] with frame held high in repeat mode.

Reset
REQ-031 SHALL, on rst, asynchronously force state IDLE, q=0, frame=0, busy=0, done=0, pat_r=0, len_r=MAX_LEN, index=0 and pending slot empty.
REQ-032 SHALL, on rst mid-sequence, take effect immediately without completing the period, with no done pulse.

Configuration
REQ-033 SHALL, with macro SEQSIG_PERIOD_CNT_EN defined, add output port period_cnt[15:0] that increments on each completed period, saturates at 16'hFFFF, clears on start and on rst, and holds in IDLE.
REQ-034 SHALL, without SEQSIG_PERIOD_CNT_EN, have no period_cnt port and no counter logic.

Verification
REQ-035 SHALL cover: MAX_LEN=16, load pat=6'b110100 len=6, mode=0, start, en=1 -> q repeats 1,1,0,1,0,0 with frame every 6 cycles and first bit 1 cycle after start.
REQ-036 SHALL cover: len=3 pat=3'b101 mode=1 -> q=1,0,1, then done pulse with busy=0 and q=0, then idle.
REQ-037 SHALL cover: en=0 for 3 cycles after bit 2 of a len=4 run -> q held 3 cycles, then resumes at bit 1, and period length becomes 7 cycles.
REQ-038 SHALL cover: load pat=4'b1000 len=4 mid-period while running pattern 4'b1111 -> remaining 1s finish, next period is 1,0,0,0.
REQ-039 SHALL cover: start and stop in same cycle -> stays IDLE; stop mid-run -> q=0 and busy=0 next cycle, no done.
REQ-040 SHALL cover: rst asserted mid-period, asynchronously between clock edges -> all outputs 0 immediately; with SEQSIG_PERIOD_CNT_EN, period_cnt=0.
